// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, states and constants for the multiply/divide unit
package mdu_pkg;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    localparam int          STEPS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement magnitude for signed ops; unsigned ops pass through.
    // 0x80000000 maps to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
module mdu_step
    import mdu_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        bit_in,
    input  logic        is_div,
    output logic [63:0] acc_next
);

    logic [32:0] trial;
    logic [31:0] diff;

    // Multiply consumes multiplier bits MSB-first; divide keeps the partial
    // remainder in acc[63:32] and shifts quotient bits into acc[31:0].
    always_comb begin
        acc_next = '0;
        trial    = '0;
        diff     = '0;
        if (!is_div) begin
            acc_next = {acc[62:0], 1'b0} + (bit_in ? {32'd0, operand} : 64'd0);
        end else begin
            trial = {acc[63:32], bit_in};
            diff  = trial[31:0] - operand;
            if (trial >= {1'b0, operand}) begin
                acc_next = {diff, acc[30:0], 1'b1};
            end else begin
                acc_next = {trial[31:0], acc[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] shreg;
    logic        is_div;
    logic        sign_q;
    logic        sign_r;
    logic        div0;

    logic        accept;
    logic        is_signed;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] div0_hi;

    assign accept    = (state == IDLE) && start;
    assign is_signed = op[0];
    assign busy      = (state != IDLE);

    // Multiply steps use the multiplicand as addend; divide steps use the divisor.
    mdu_step u_step (
        .acc      (acc),
        .operand  (is_div ? mag_b : mag_a),
        .bit_in   (shreg[31]),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: only ops 0-3 launch the engine; MTHI/MTLO and no-ops stay idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !op[2]) state_next = CALC;
            CALC: if (cnt == 5'(STEPS - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign-corrected results; divide by zero returns the original dividend in HI.
    always_comb begin
        prod    = sign_q ? (~acc + 64'd1) : acc;
        quot    = sign_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem     = sign_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        div0_hi = sign_r ? (~mag_a + 32'd1) : mag_a;
    end

    // Operand capture, iteration datapath, HI/LO writeback and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            shreg  <= '0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            HI <= RsData;
                        end else if (op == OP_MTLO) begin
                            LO <= RsData;
                        end else if (!op[2]) begin
                            mag_a  <= mag32(RsData, is_signed);
                            mag_b  <= mag32(RtData, is_signed);
                            shreg  <= op[1] ? mag32(RsData, is_signed) : mag32(RtData, is_signed);
                            is_div <= op[1];
                            sign_q <= is_signed & (RsData[31] ^ RtData[31]);
                            sign_r <= is_signed & RsData[31];
                            div0   <= (RtData == 32'd0);
                            acc    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    shreg <= {shreg[30:0], 1'b0};
                    cnt   <= cnt + 5'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        HI <= prod[63:32];
                        LO <= prod[31:0];
                    end else if (div0) begin
                        HI <= div0_hi;
                        LO <= DIV0_LO;
                    end else begin
                        HI <= rem;
                        LO <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .RsData (RsData),
        .RtData (RtData),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and the remainder takes the dividend's sign.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, q, r;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 'x;
        lo = 'x;
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin hi = a % b; lo = a / b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
        endcase
    endtask

    // Present a request for one edge, then scramble operands to prove capture.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        RsData = a;
        RtData = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'd7;
        RsData = $urandom;
        RtData = $urandom;
    endtask

    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && n < 100);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          n;
        bit          bok;
        logic [31:0] eh, el;
        model(o, a, b, eh, el);
        issue(o, a, b);
        wait_done(n, bok);
        check({name, " latency"}, 64'(n), 64'd33);
        check({name, " busy in flight"}, 64'(bok), 64'd1);
        check({name, " busy in done cycle"}, 64'(busy), 64'd0);
        check({name, " HI"}, 64'(HI), 64'(eh));
        check({name, " LO"}, 64'(LO), 64'(el));
    endtask

    initial begin
        int          n;
        int          done_seen;
        bit          bok;
        logic [31:0] eh, el, ra, rb;
        logic [2:0]  ro;

        rst = 1'b1; start = 1'b0; op = 3'd0; RsData = '0; RtData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        rst = 1'b0;

        run("multu max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max HI const", 64'(HI), 64'h0000_0000_FFFF_FFFE);
        check("multu max LO const", 64'(LO), 64'h0000_0000_0000_0001);
        run("mult -3*7", 3'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult LO const", 64'(LO), 64'h0000_0000_FFFF_FFEB);
        run("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        check("div LO const", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        run("divu 7/2 b2b", 3'd2, 32'd7, 32'd2);
        check("divu HI const", 64'(HI), 64'd1);
        run("div overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("overflow LO const", 64'(LO), 64'h0000_0000_8000_0000);
        run("divu by zero", 3'd2, 32'd5, 32'd0);
        run("div by zero neg", 3'd3, 32'hFFFF_FF00, 32'd0);

        // Start while busy is ignored.
        model(3'd1, 32'h0000_0123, 32'hFFFF_FF00, eh, el);
        issue(3'd1, 32'h0000_0123, 32'hFFFF_FF00);
        repeat (4) @(posedge clk);
        #1;
        issue(3'd0, 32'h1111_1111, 32'h2222_2222);
        wait_done(n, bok);
        check("busy-start latency", 64'(n), 64'd28);
        check("busy-start HI", 64'(HI), 64'(eh));
        check("busy-start LO", 64'(LO), 64'(el));
        @(posedge clk);
        #1;
        check("busy-start no relaunch", 64'(busy), 64'd0);

        // Reset during a divide.
        issue(3'd3, 32'h7654_3210, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset HI", 64'(HI), 64'd0);
        check("midreset LO", 64'(LO), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("midreset no done", 64'(done_seen), 64'd0);

        // MTHI / MTLO / no-op.
        issue(3'd4, 32'h0000_1234, 32'hDEAD_BEEF);
        check("mthi HI", 64'(HI), 64'h1234);
        check("mthi LO", 64'(LO), 64'd0);
        check("mthi busy", 64'(busy), 64'd0);
        issue(3'd5, 32'h0000_ABCD, 32'd0);
        check("mtlo LO", 64'(LO), 64'hABCD);
        check("mtlo HI", 64'(HI), 64'h1234);
        issue(3'd6, 32'h5555_5555, 32'd1);
        @(posedge clk);
        #1;
        check("op6 busy", 64'(busy), 64'd0);
        check("op6 HI", 64'(HI), 64'h1234);
        check("op6 LO", 64'(LO), 64'hABCD);

        // Random operations against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
            run("random", ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
